// File: rtl/mdu_pkg.sv
// mdu_pkg: shared definitions for the multiply/divide controller.
//   - MDU_op encodings (MDU_NONE..MDU_MFLO)
//   - default multiply/divide latencies
//   - countdown counter width
//   - controller state encoding and an op-class helper
package mdu_pkg;

    localparam int CNT_W       = 4;
    localparam int MUL_LAT_DEF = 5;
    localparam int DIV_LAT_DEF = 10;

    typedef enum logic [3:0] {
        MDU_NONE  = 4'd0,
        MDU_MULT  = 4'd1,
        MDU_MULTU = 4'd2,
        MDU_DIV   = 4'd3,
        MDU_DIVU  = 4'd4,
        MDU_MTHI  = 4'd5,
        MDU_MTLO  = 4'd6,
        MDU_MFHI  = 4'd7,
        MDU_MFLO  = 4'd8
    } mdu_op_e;

    // IDLE <=> count == 0, RUN <=> count != 0
    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } mdu_state_e;

    // True for the four ops that occupy the unit for several cycles.
    function automatic logic is_muldiv(input logic [3:0] op);
        return (op >= 4'd1) && (op <= 4'd4);
    endfunction

endpackage

// File: rtl/mdu_arith.sv
// mdu_arith: pure combinational multiply/divide datapath.
// Ports:
//   op       in  4   MDU op (only MULT/MULTU/DIV/DIVU produce a result)
//   src1     in  32  rs operand (multiplicand / dividend)
//   src2     in  32  rt operand (multiplier / divisor)
//   hi       out 32  high product word or remainder
//   lo       out 32  low product word or quotient
//   div_zero out 1   DIV/DIVU with a zero divisor
module mdu_arith
    import mdu_pkg::*;
(
    input  logic [3:0]  op,
    input  logic [31:0] src1,
    input  logic [31:0] src2,
    output logic [31:0] hi,
    output logic [31:0] lo,
    output logic        div_zero
);

    logic [63:0] s_prod;
    logic [63:0] u_prod;
    logic        signed_div;
    logic [31:0] a_mag;
    logic [31:0] b_mag;
    logic [31:0] divisor;
    logic [31:0] q_mag;
    logic [31:0] r_mag;

    always_comb begin
        // Explicit sign/zero extension to 64 bits keeps both products exact
        // without relying on expression-context signedness rules.
        s_prod = {{32{src1[31]}}, src1} * {{32{src2[31]}}, src2};
        u_prod = {32'd0, src1} * {32'd0, src2};

        // Signed divide runs on magnitudes and fixes the signs afterwards:
        // quotient truncates toward zero, remainder follows the dividend.
        // This also gives a defined answer for 0x80000000 / -1.
        signed_div = (op == MDU_DIV);
        a_mag      = (signed_div && src1[31]) ? (32'd0 - src1) : src1;
        b_mag      = (signed_div && src2[31]) ? (32'd0 - src2) : src2;
        // Substitute a divisor of 1 on zero so the divider never sees /0;
        // the result is discarded via div_zero anyway.
        divisor    = (src2 == 32'd0) ? 32'd1 : b_mag;
        q_mag      = a_mag / divisor;
        r_mag      = a_mag % divisor;

        div_zero   = ((op == MDU_DIV) || (op == MDU_DIVU)) && (src2 == 32'd0);

        hi = 32'd0;
        lo = 32'd0;
        case (op)
            MDU_MULT:  {hi, lo} = s_prod;
            MDU_MULTU: {hi, lo} = u_prod;
            MDU_DIV: begin
                lo = (src1[31] ^ src2[31]) ? (32'd0 - q_mag) : q_mag;
                hi = src1[31] ? (32'd0 - r_mag) : r_mag;
            end
            MDU_DIVU: begin
                lo = q_mag;
                hi = r_mag;
            end
            default: begin
                hi = 32'd0;
                lo = 32'd0;
            end
        endcase
    end

endmodule

// File: rtl/mdu_ctrl.sv
// mdu_ctrl: multi-cycle multiply/divide controller beside the E-stage ALU.
// The result is computed when the op is accepted and held in pending
// registers; a countdown models the unit latency and HI/LO are written
// when the count reaches zero.
// Ports:
//   clk          in  1   rising-edge clock
//   rst_n        in  1   synchronous active-low reset
//   MDU_src1     in  32  rs operand (also the MTHI/MTLO write data)
//   MDU_src2     in  32  rt operand
//   MDU_op       in  4   operation (see mdu_pkg::mdu_op_e; others = NONE)
//   MDU_start    in  1   one-cycle start pulse for ops 1..4
//   MDU_busy     out 1   registered, high while a mul/div is in flight
//   MDU_stall    out 1   freeze D/E: (busy | start) & op != NONE
//   E_MDU_result out 32  HI for MFHI, LO for MFLO, else 0
//
// Handshake: MDU_start is a request that is accepted only in a cycle where
// MDU_busy is low. MDU_stall is the "not ready" back to the pipeline; a
// start or HI/LO access presented while busy is not consumed and must be
// re-presented by the pipeline once MDU_stall drops.
module mdu_ctrl
    import mdu_pkg::*;
#(
    parameter int MUL_LAT = MUL_LAT_DEF,
    parameter int DIV_LAT = DIV_LAT_DEF
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] MDU_src1,
    input  logic [31:0] MDU_src2,
    input  logic [3:0]  MDU_op,
    input  logic        MDU_start,
    output logic        MDU_busy,
    output logic        MDU_stall,
    output logic [31:0] E_MDU_result
);

    localparam logic [CNT_W-1:0] MUL_CNT = CNT_W'(MUL_LAT);
    localparam logic [CNT_W-1:0] DIV_CNT = CNT_W'(DIV_LAT);

    mdu_state_e       state_q, state_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic [31:0]      pending_hi_q, pending_hi_d;
    logic [31:0]      pending_lo_q, pending_lo_d;
    logic             pending_valid_q, pending_valid_d;
    logic [31:0]      hi_q, hi_d;
    logic [31:0]      lo_q, lo_d;

    logic [31:0]      arith_hi;
    logic [31:0]      arith_lo;
    logic             arith_div_zero;
    logic             op_active;

    mdu_arith u_arith (
        .op       (MDU_op),
        .src1     (MDU_src1),
        .src2     (MDU_src2),
        .hi       (arith_hi),
        .lo       (arith_lo),
        .div_zero (arith_div_zero)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q         <= ST_IDLE;
            count_q         <= '0;
            pending_hi_q    <= '0;
            pending_lo_q    <= '0;
            pending_valid_q <= 1'b0;
            hi_q            <= '0;
            lo_q            <= '0;
        end else begin
            state_q         <= state_d;
            count_q         <= count_d;
            pending_hi_q    <= pending_hi_d;
            pending_lo_q    <= pending_lo_d;
            pending_valid_q <= pending_valid_d;
            hi_q            <= hi_d;
            lo_q            <= lo_d;
        end
    end

    always_comb begin
        state_d         = state_q;
        count_d         = count_q;
        pending_hi_d    = pending_hi_q;
        pending_lo_d    = pending_lo_q;
        pending_valid_d = pending_valid_q;
        hi_d            = hi_q;
        lo_d            = lo_q;

        case (state_q)
            ST_IDLE: begin
                if (MDU_start && is_muldiv(MDU_op)) begin
                    pending_hi_d    = arith_hi;
                    pending_lo_d    = arith_lo;
                    // A zero divisor still takes the full latency but
                    // leaves HI/LO untouched at commit.
                    pending_valid_d = !arith_div_zero;
                    count_d         = ((MDU_op == MDU_MULT) || (MDU_op == MDU_MULTU))
                                      ? MUL_CNT : DIV_CNT;
                    state_d         = ST_RUN;
                end else if (!MDU_start && (MDU_op == MDU_MTHI)) begin
                    hi_d = MDU_src1;
                end else if (!MDU_start && (MDU_op == MDU_MTLO)) begin
                    lo_d = MDU_src1;
                end
            end
            ST_RUN: begin
                // Starts and moves are not accepted here; only the commit
                // can write HI/LO, so it wins over any forced MTHI/MTLO.
                count_d = count_q - CNT_W'(1);
                if (count_q == CNT_W'(1)) begin
                    state_d = ST_IDLE;
                    if (pending_valid_q) begin
                        hi_d = pending_hi_q;
                        lo_d = pending_lo_q;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Encodings 9..15 behave like NONE and never stall.
    assign op_active = (MDU_op != MDU_NONE) && (MDU_op <= MDU_MFLO);
    assign MDU_busy  = (state_q == ST_RUN);
    assign MDU_stall = (MDU_busy || MDU_start) && op_active;

    always_comb begin
        E_MDU_result = 32'd0;
        if (MDU_op == MDU_MFHI) begin
            E_MDU_result = hi_q;
        end else if (MDU_op == MDU_MFLO) begin
            E_MDU_result = lo_q;
        end
    end

endmodule

// File: tb/tb_mdu_ctrl.sv
// tb_mdu_ctrl: directed tests for mdu_ctrl with hand-computed expectations.
module tb_mdu_ctrl;
    import mdu_pkg::*;

    logic        clk;
    logic        rst_n;
    logic [31:0] s1;
    logic [31:0] s2;
    logic [3:0]  op;
    logic        start;
    logic        busy;
    logic        stall;
    logic [31:0] res;

    int n_cmp = 0;
    int n_err = 0;

    mdu_ctrl #(.MUL_LAT(5), .DIV_LAT(10)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .MDU_src1     (s1),
        .MDU_src2     (s2),
        .MDU_op       (op),
        .MDU_start    (start),
        .MDU_busy     (busy),
        .MDU_stall    (stall),
        .E_MDU_result (res)
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- driver tasks ----------------
    // Advance to just after the next rising edge.
    task automatic cycle();
        @(posedge clk);
        #1;
    endtask

    // Read HI and LO through MFHI/MFLO within the current cycle, then
    // restore the op that was being presented.
    task automatic read_hilo(output logic [31:0] hi, output logic [31:0] lo);
        logic [3:0] saved;
        saved = op;
        op = MDU_MFHI;
        #1 hi = res;
        op = MDU_MFLO;
        #1 lo = res;
        op = saved;
        #1;
    endtask

    // Issue a start, then count cycles with busy high (bounded).
    task automatic run_op(input logic [3:0] o, input logic [31:0] a,
                          input logic [31:0] b, output int n);
        op = o;
        s1 = a;
        s2 = b;
        start = 1'b1;
        cycle();
        start = 1'b0;
        op = MDU_NONE;
        n = 0;
        while (busy === 1'b1 && n < 40) begin
            n++;
            cycle();
        end
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        logic [31:0] h, l;
        rst_n = 1'b0;
        op = MDU_NONE; s1 = '0; s2 = '0; start = 1'b0;
        repeat (3) cycle();
        rst_n = 1'b1;
        n_cmp++;
        if (busy !== 1'b0) begin n_err++; $display("FAIL reset_busy: got %b expected 0", busy); end
        n_cmp++;
        if (stall !== 1'b0) begin n_err++; $display("FAIL reset_stall: got %b expected 0", stall); end
        read_hilo(h, l);
        n_cmp++;
        if (h !== 32'h0) begin n_err++; $display("FAIL reset_hi: got %h expected 00000000", h); end
        n_cmp++;
        if (l !== 32'h0) begin n_err++; $display("FAIL reset_lo: got %h expected 00000000", l); end
    endtask

    task automatic test_mult();
        logic [31:0] h, l;
        int n;
        op = MDU_MULT; s1 = 32'hFFFF_FFFE; s2 = 32'd3; start = 1'b1;
        #1;
        n_cmp++;
        if (stall !== 1'b1) begin n_err++; $display("FAIL mult_start_stall: got %b expected 1", stall); end
        start = 1'b0;
        run_op(MDU_MULT, 32'hFFFF_FFFE, 32'd3, n);
        n_cmp++;
        if (n !== 5) begin n_err++; $display("FAIL mult_busy_cycles: got %0d expected 5", n); end
        read_hilo(h, l);
        n_cmp++;
        if (h !== 32'hFFFF_FFFF) begin n_err++; $display("FAIL mult_hi: got %h expected ffffffff", h); end
        n_cmp++;
        if (l !== 32'hFFFF_FFFA) begin n_err++; $display("FAIL mult_lo: got %h expected fffffffa", l); end

        run_op(MDU_MULTU, 32'hFFFF_FFFE, 32'd3, n);
        n_cmp++;
        if (n !== 5) begin n_err++; $display("FAIL multu_busy_cycles: got %0d expected 5", n); end
        read_hilo(h, l);
        n_cmp++;
        if (h !== 32'h0000_0002) begin n_err++; $display("FAIL multu_hi: got %h expected 00000002", h); end
        n_cmp++;
        if (l !== 32'hFFFF_FFFA) begin n_err++; $display("FAIL multu_lo: got %h expected fffffffa", l); end
    endtask

    task automatic test_div();
        logic [31:0] h, l;
        int n;
        run_op(MDU_DIV, 32'hFFFF_FFF9, 32'd2, n);
        n_cmp++;
        if (n !== 10) begin n_err++; $display("FAIL div_busy_cycles: got %0d expected 10", n); end
        read_hilo(h, l);
        n_cmp++;
        if (h !== 32'hFFFF_FFFF) begin n_err++; $display("FAIL div_hi: got %h expected ffffffff", h); end
        n_cmp++;
        if (l !== 32'hFFFF_FFFD) begin n_err++; $display("FAIL div_lo: got %h expected fffffffd", l); end

        run_op(MDU_DIVU, 32'd7, 32'd2, n);
        n_cmp++;
        if (n !== 10) begin n_err++; $display("FAIL divu_busy_cycles: got %0d expected 10", n); end
        read_hilo(h, l);
        n_cmp++;
        if (h !== 32'd1) begin n_err++; $display("FAIL divu_hi: got %h expected 00000001", h); end
        n_cmp++;
        if (l !== 32'd3) begin n_err++; $display("FAIL divu_lo: got %h expected 00000003", l); end
    endtask

    task automatic test_move();
        logic [31:0] h, l;
        int n;
        op = MDU_MTHI; s1 = 32'h1234_5678; s2 = '0;
        #1;
        n_cmp++;
        if (stall !== 1'b0) begin n_err++; $display("FAIL mthi_idle_stall: got %b expected 0", stall); end
        cycle();
        op = MDU_NONE;
        read_hilo(h, l);
        n_cmp++;
        if (h !== 32'h1234_5678) begin n_err++; $display("FAIL mthi_hi: got %h expected 12345678", h); end

        // DIVU 100/7 = 14 r 2, with MTLO held against it the whole time.
        op = MDU_DIVU; s1 = 32'd100; s2 = 32'd7; start = 1'b1;
        cycle();
        start = 1'b0;
        op = MDU_MTLO; s1 = 32'hDEAD_BEEF;
        n = 0;
        while (busy === 1'b1 && n < 40) begin
            n++;
            n_cmp++;
            if (stall !== 1'b1) begin n_err++; $display("FAIL mtlo_busy_stall: cycle %0d got %b expected 1", n, stall); end
            if (n == 3) begin
                read_hilo(h, l);
                n_cmp++;
                if (l !== 32'd3) begin n_err++; $display("FAIL mtlo_lo_mid_run: got %h expected 00000003", l); end
            end
            cycle();
        end
        n_cmp++;
        if (n !== 10) begin n_err++; $display("FAIL mtlo_div_busy_cycles: got %0d expected 10", n); end
        n_cmp++;
        if (stall !== 1'b0) begin n_err++; $display("FAIL mtlo_after_stall: got %b expected 0", stall); end
        read_hilo(h, l);
        n_cmp++;
        if (l !== 32'd14) begin n_err++; $display("FAIL mtlo_commit_lo: got %h expected 0000000e", l); end
        n_cmp++;
        if (h !== 32'd2) begin n_err++; $display("FAIL mtlo_commit_hi: got %h expected 00000002", h); end
        // Re-presented MTLO now takes effect.
        cycle();
        op = MDU_NONE;
        read_hilo(h, l);
        n_cmp++;
        if (l !== 32'hDEAD_BEEF) begin n_err++; $display("FAIL mtlo_retry_lo: got %h expected deadbeef", l); end
    endtask

    task automatic test_div_zero();
        logic [31:0] h, l;
        int n;
        op = MDU_MTHI; s1 = 32'hAA;
        cycle();
        op = MDU_MTLO; s1 = 32'hBB;
        cycle();
        run_op(MDU_DIV, 32'd5, 32'd0, n);
        n_cmp++;
        if (n !== 10) begin n_err++; $display("FAIL divzero_busy_cycles: got %0d expected 10", n); end
        read_hilo(h, l);
        n_cmp++;
        if (h !== 32'hAA) begin n_err++; $display("FAIL divzero_hi: got %h expected 000000aa", h); end
        n_cmp++;
        if (l !== 32'hBB) begin n_err++; $display("FAIL divzero_lo: got %h expected 000000bb", l); end
    endtask

    task automatic test_reset_mid();
        logic [31:0] h, l;
        op = MDU_MULT; s1 = 32'd4; s2 = 32'd5; start = 1'b1;
        cycle();
        start = 1'b0;
        op = MDU_NONE;
        cycle();
        cycle();
        // Now in the third busy cycle.
        n_cmp++;
        if (busy !== 1'b1) begin n_err++; $display("FAIL rstmid_busy_before: got %b expected 1", busy); end
        rst_n = 1'b0;
        cycle();
        rst_n = 1'b1;
        n_cmp++;
        if (busy !== 1'b0) begin n_err++; $display("FAIL rstmid_busy: got %b expected 0", busy); end
        read_hilo(h, l);
        n_cmp++;
        if (h !== 32'h0 || l !== 32'h0) begin
            n_err++; $display("FAIL rstmid_hilo: got %h/%h expected 00000000/00000000", h, l);
        end
        repeat (6) cycle();
        read_hilo(h, l);
        n_cmp++;
        if (h !== 32'h0 || l !== 32'h0) begin
            n_err++; $display("FAIL rstmid_no_late_commit: got %h/%h expected 00000000/00000000", h, l);
        end
    endtask

    task automatic test_back_to_back();
        logic [31:0] h, l;
        int n;
        op = MDU_MULTU; s1 = 32'd6; s2 = 32'd7; start = 1'b1;
        cycle();
        start = 1'b0;
        op = MDU_NONE;
        n = 0;
        while (busy === 1'b1 && n < 40) begin
            n++;
            if (n == 2) begin
                // Illegal second start: must not restart or change the result.
                op = MDU_MULT; s1 = 32'd100; s2 = 32'd100; start = 1'b1;
                #1;
                n_cmp++;
                if (stall !== 1'b1) begin n_err++; $display("FAIL b2b_restart_stall: got %b expected 1", stall); end
            end else if (n == 3) begin
                op = 4'hF; start = 1'b0;
                #1;
                n_cmp++;
                if (stall !== 1'b0) begin n_err++; $display("FAIL b2b_unknown_op_stall: got %b expected 0", stall); end
            end else begin
                op = MDU_NONE; start = 1'b0;
            end
            cycle();
        end
        op = MDU_NONE;
        n_cmp++;
        if (n !== 5) begin n_err++; $display("FAIL b2b_busy_cycles: got %0d expected 5", n); end
        read_hilo(h, l);
        n_cmp++;
        if (l !== 32'd42) begin n_err++; $display("FAIL b2b_lo: got %h expected 0000002a", l); end
        n_cmp++;
        if (h !== 32'd0) begin n_err++; $display("FAIL b2b_hi: got %h expected 00000000", h); end
    endtask

    // ---------------- sequence + final report ----------------
    initial begin
        rst_n = 1'b0;
        op = MDU_NONE; s1 = '0; s2 = '0; start = 1'b0;
        test_reset();
        test_mult();
        test_div();
        test_move();
        test_div_zero();
        test_reset_mid();
        test_back_to_back();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

endmodule
